rs_age_issue: RTL and testbench

- Parametrised successor to the 8-entry ALU reservation station.
- Generalises depth, operand width, op width and number of result-broadcast (CDB) channels.
- Adds oldest-first issue via an age matrix, a registered valid/ready issue handshake to the ALU, and an occupancy count.
- Sits between Decoder dispatch and the ALU; snoops all CDB result channels (ALU, LSB, ...).

---
 rtl/rs_age_issue_if.sv | 47 ++++
 rtl/rs_age_issue.sv | 186 ++++++++++++++++++
 tb/tb_rs_age_issue.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_age_issue_if.sv
// Dispatch, CDB snoop, issue handshake and occupancy bundle for rs_age_issue.
// master = Decoder/CDB/ALU side, slave = reservation station.
interface rs_age_issue_if #(
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32,
    parameter int CDB_N  = 2,
    parameter int CNT_W  = 4
) ();
    logic                    rs_full;
    logic [CNT_W-1:0]        rs_count;

    logic                    inst_valid;
    logic [OP_W-1:0]         inst_op;
    logic [ROB_W-1:0]        inst_robid;
    logic [DATA_W-1:0]       inst_val1;
    logic [DATA_W-1:0]       inst_val2;
    logic                    inst_has_rely1;
    logic                    inst_has_rely2;
    logic [ROB_W-1:0]        inst_rely1;
    logic [ROB_W-1:0]        inst_rely2;

    logic [CDB_N-1:0]        cdb_valid;
    logic [CDB_N*ROB_W-1:0]  cdb_robid;
    logic [CDB_N*DATA_W-1:0] cdb_val;

    logic                    iss_valid;
    logic                    iss_ready;
    logic [OP_W-1:0]         iss_op;
    logic [DATA_W-1:0]       iss_rs1;
    logic [DATA_W-1:0]       iss_rs2;
    logic [ROB_W-1:0]        iss_robid;

    modport master (
        input  rs_full, rs_count, iss_valid, iss_op, iss_rs1, iss_rs2, iss_robid,
        output inst_valid, inst_op, inst_robid, inst_val1, inst_val2,
               inst_has_rely1, inst_has_rely2, inst_rely1, inst_rely2,
               cdb_valid, cdb_robid, cdb_val, iss_ready
    );

    modport slave (
        output rs_full, rs_count, iss_valid, iss_op, iss_rs1, iss_rs2, iss_robid,
        input  inst_valid, inst_op, inst_robid, inst_val1, inst_val2,
               inst_has_rely1, inst_has_rely2, inst_rely1, inst_rely2,
               cdb_valid, cdb_robid, cdb_val, iss_ready
    );
endinterface

// File: rtl/rs_age_issue.sv
// Age-ordered ALU reservation station: CDB wakeup, oldest-ready issue into a registered slot.
// Latency 1 cycle dispatch->iss_valid; slot holds while !iss_ready. Define RS_PERF_EN for perf counters.
module rs_age_issue #(
    parameter int RS_DEPTH = 8,
    parameter int ROB_W    = 4,
    parameter int OP_W     = 6,
    parameter int DATA_W   = 32,
    parameter int CDB_N    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rs_clear,
    rs_age_issue_if.slave bus
`ifdef RS_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall
`endif
);
    localparam int IW = $clog2(RS_DEPTH);
    localparam int CW = IW + 1;

    logic [RS_DEPTH-1:0] busy, qj_pend, qk_pend, ready;
    logic [OP_W-1:0]     op_q  [RS_DEPTH];
    logic [ROB_W-1:0]    rob_q [RS_DEPTH];
    logic [ROB_W-1:0]    qj    [RS_DEPTH];
    logic [ROB_W-1:0]    qk    [RS_DEPTH];
    logic [DATA_W-1:0]   vj    [RS_DEPTH];
    logic [DATA_W-1:0]   vk    [RS_DEPTH];
    logic [RS_DEPTH-1:0] older [RS_DEPTH];

    logic [CW-1:0]       count_q, cnt_nxt;
    logic                full_q;
    logic                iss_valid_q;
    logic [OP_W-1:0]     iss_op_q;
    logic [DATA_W-1:0]   iss_rs1_q, iss_rs2_q;
    logic [ROB_W-1:0]    iss_rob_q;

    logic                dispatch, load, do_issue, sel_found;
    logic [IW-1:0]       free_idx, sel_idx;
    logic                d_pj, d_pk;
    logic [DATA_W-1:0]   d_vj, d_vk;

    assign ready    = busy & ~qj_pend & ~qk_pend;
    assign dispatch = bus.inst_valid && !full_q;
    assign load     = !iss_valid_q || bus.iss_ready;
    assign do_issue = load && sel_found;
    assign cnt_nxt  = count_q + CW'(dispatch) - CW'(do_issue);

    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--)
            if (!busy[i]) free_idx = IW'(i);
    end

    // Exactly one ready entry is older than all other ready entries.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++)
            if (ready[i] && &(older[i] | ~ready | (RS_DEPTH'(1) << i))) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
    end

    // Dispatch-time bypass; descending loop lets the lowest channel win.
    always_comb begin
        d_pj = bus.inst_has_rely1;
        d_pk = bus.inst_has_rely2;
        d_vj = bus.inst_val1;
        d_vk = bus.inst_val2;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (bus.inst_has_rely1 && bus.cdb_valid[k] &&
                bus.cdb_robid[k*ROB_W +: ROB_W] == bus.inst_rely1) begin
                d_pj = 1'b0;
                d_vj = bus.cdb_val[k*DATA_W +: DATA_W];
            end
            if (bus.inst_has_rely2 && bus.cdb_valid[k] &&
                bus.cdb_robid[k*ROB_W +: ROB_W] == bus.inst_rely2) begin
                d_pk = 1'b0;
                d_vk = bus.cdb_val[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy        <= '0;
            qj_pend     <= '0;
            qk_pend     <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_rs1_q   <= '0;
            iss_rs2_q   <= '0;
            iss_rob_q   <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                older[i] <= '0;
                op_q[i]  <= '0;
                rob_q[i] <= '0;
                qj[i]    <= '0;
                qk[i]    <= '0;
                vj[i]    <= '0;
                vk[i]    <= '0;
            end
        end else if (rs_clear) begin
            busy        <= '0;
            qj_pend     <= '0;
            qk_pend     <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_rs1_q   <= '0;
            iss_rs2_q   <= '0;
            iss_rob_q   <= '0;
            for (int i = 0; i < RS_DEPTH; i++) older[i] <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_DEPTH; i++)
                for (int k = CDB_N - 1; k >= 0; k--) begin
                    if (busy[i] && qj_pend[i] && bus.cdb_valid[k] &&
                        bus.cdb_robid[k*ROB_W +: ROB_W] == qj[i]) begin
                        qj_pend[i] <= 1'b0;
                        vj[i]      <= bus.cdb_val[k*DATA_W +: DATA_W];
                    end
                    if (busy[i] && qk_pend[i] && bus.cdb_valid[k] &&
                        bus.cdb_robid[k*ROB_W +: ROB_W] == qk[i]) begin
                        qk_pend[i] <= 1'b0;
                        vk[i]      <= bus.cdb_val[k*DATA_W +: DATA_W];
                    end
                end

            if (dispatch) begin
                busy[free_idx]    <= 1'b1;
                op_q[free_idx]    <= bus.inst_op;
                rob_q[free_idx]   <= bus.inst_robid;
                qj[free_idx]      <= bus.inst_rely1;
                qk[free_idx]      <= bus.inst_rely2;
                qj_pend[free_idx] <= d_pj;
                qk_pend[free_idx] <= d_pk;
                vj[free_idx]      <= d_vj;
                vk[free_idx]      <= d_vk;
                older[free_idx]   <= '0;
                for (int i = 0; i < RS_DEPTH; i++)
                    if (busy[i]) older[i][free_idx] <= 1'b1;
            end

            if (load) begin
                iss_valid_q <= sel_found;
                if (sel_found) begin
                    busy[sel_idx] <= 1'b0;
                    iss_op_q      <= op_q[sel_idx];
                    iss_rs1_q     <= vj[sel_idx];
                    iss_rs2_q     <= vk[sel_idx];
                    iss_rob_q     <= rob_q[sel_idx];
                end
            end

            count_q <= cnt_nxt;
            full_q  <= (cnt_nxt == CW'(RS_DEPTH));
        end
    end

`ifdef RS_PERF_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else if (!rs_clear && rdy_in) begin
            perf_issued <= perf_issued + 32'(do_issue);
            perf_stall  <= perf_stall + 32'(bus.inst_valid && full_q);
        end
    end
`endif

    assign bus.rs_full   = full_q;
    assign bus.rs_count  = count_q;
    assign bus.iss_valid = iss_valid_q;
    assign bus.iss_op    = iss_op_q;
    assign bus.iss_rs1   = iss_rs1_q;
    assign bus.iss_rs2   = iss_rs2_q;
    assign bus.iss_robid = iss_rob_q;
endmodule

// File: tb/tb_rs_age_issue.sv
// Scoreboard bench for rs_age_issue: expected issues queued at dispatch, popped on handshake.
module tb_rs_age_issue;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, rs_clear;

    rs_age_issue_if #(.ROB_W(4), .OP_W(6), .DATA_W(32), .CDB_N(2), .CNT_W(4)) bus ();

    rs_age_issue #(.RS_DEPTH(8), .ROB_W(4), .OP_W(6), .DATA_W(32), .CDB_N(2)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .rs_clear (rs_clear),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    logic [73:0] sb_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [73:0] pk(input logic [5:0] op, input logic [3:0] rob,
                                       input logic [31:0] a, input logic [31:0] b);
        return {op, rob, a, b};
    endfunction

    always @(negedge clk_in)
        if (!rst_in && rdy_in && !rs_clear && bus.iss_valid && bus.iss_ready) begin
            if (sb_q.size() == 0)
                check("unexp_issue", sb_q.size(), 1);
            else
                check("issue", pk(bus.iss_op, bus.iss_robid, bus.iss_rs1, bus.iss_rs2),
                      sb_q.pop_front());
        end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.inst_valid     = 1'b0;
        bus.inst_has_rely1 = 1'b0;
        bus.inst_has_rely2 = 1'b0;
        bus.cdb_valid      = '0;
    endtask

    task automatic set_disp(input logic [5:0] op, input logic [3:0] rob,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic h1, input logic [3:0] r1,
                            input logic h2, input logic [3:0] r2);
        bus.inst_valid     = 1'b1;
        bus.inst_op        = op;
        bus.inst_robid     = rob;
        bus.inst_val1      = v1;
        bus.inst_val2      = v2;
        bus.inst_has_rely1 = h1;
        bus.inst_rely1     = r1;
        bus.inst_has_rely2 = h2;
        bus.inst_rely2     = r2;
    endtask

    task automatic set_cdb(input int ch, input logic [3:0] rob, input logic [31:0] val);
        bus.cdb_valid[ch]          = 1'b1;
        bus.cdb_robid[ch*4 +: 4]   = rob;
        bus.cdb_val[ch*32 +: 32]   = val;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rs_clear = 1'b0;
        bus.iss_ready = 1'b0;
        bus.cdb_robid = '0; bus.cdb_val = '0;
        bus.inst_op = '0; bus.inst_robid = '0; bus.inst_val1 = '0; bus.inst_val2 = '0;
        bus.inst_rely1 = '0; bus.inst_rely2 = '0;
        idle();
        repeat (2) tick();
        rst_in = 1'b0;
        tick();

        // Async reset mid-cycle with a loaded slot and one entry resident
        set_disp(6'd1, 4'd1, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        set_disp(6'd2, 4'd2, 32'd2, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        idle();
        check("pre_rst_vld", bus.iss_valid, 1);
        check("pre_rst_cnt", bus.rs_count, 1);
        #3;
        rst_in = 1'b1;
        #1;
        check("rst_vld", bus.iss_valid, 0);
        check("rst_cnt", bus.rs_count, 0);
        check("rst_full", bus.rs_full, 0);
        tick();
        rst_in = 1'b0;
        tick();

        // rdy_in low freezes everything
        rdy_in = 1'b0;
        bus.iss_ready = 1'b1;
        set_disp(6'd4, 4'd2, 32'h40, 32'h41, 1'b0, 4'd0, 1'b0, 4'd0);
        repeat (2) tick();
        check("rdy_hold_cnt", bus.rs_count, 0);
        check("rdy_hold_vld", bus.iss_valid, 0);
        sb_q.push_back(pk(6'd4, 4'd2, 32'h40, 32'h41));
        rdy_in = 1'b1;
        tick();
        idle();
        tick();
        check("rdy_vld", bus.iss_valid, 1);
        tick();

        // Fully ready op: one-cycle dispatch-to-issue
        sb_q.push_back(pk(6'd3, 4'd5, 32'd10, 32'd20));
        set_disp(6'd3, 4'd5, 32'd10, 32'd20, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        idle();
        check("lat_T", bus.iss_valid, 0);
        tick();
        check("lat_T1_vld", bus.iss_valid, 1);
        check("lat_T1_op", bus.iss_op, 3);
        check("lat_T1_rs1", bus.iss_rs1, 10);
        check("lat_T1_rs2", bus.iss_rs2, 20);
        check("lat_T1_rob", bus.iss_robid, 5);
        tick();

        // Dispatch bypass from channel 1
        sb_q.push_back(pk(6'd1, 4'd6, 32'h77, 32'd5));
        set_disp(6'd1, 4'd6, 32'h1234, 32'd5, 1'b1, 4'd2, 1'b0, 4'd0);
        set_cdb(1, 4'd2, 32'h77);
        tick();
        idle();
        tick();
        check("byp_rs1", bus.iss_rs1, 32'h77);
        tick();

        // Later wakeup from channel 0: issue one cycle after the broadcast
        sb_q.push_back(pk(6'd2, 4'd7, 32'd1, 32'd9));
        set_disp(6'd2, 4'd7, 32'd1, 32'h999, 1'b0, 4'd0, 1'b1, 4'd4);
        tick();
        idle();
        repeat (2) tick();
        check("wait_vld", bus.iss_valid, 0);
        set_cdb(0, 4'd4, 32'd9);
        tick();
        idle();
        check("wake_lat", bus.iss_valid, 0);
        tick();
        check("wake_vld", bus.iss_valid, 1);
        check("wake_rs2", bus.iss_rs2, 9);
        tick();

        // Occupy the slot, then fill all 8 entries with pending ops
        bus.iss_ready = 1'b0;
        sb_q.push_back(pk(6'h3f, 4'd0, 32'hAA, 32'hBB));
        set_disp(6'h3f, 4'd0, 32'hAA, 32'hBB, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        for (int r = 1; r <= 8; r++) begin
            set_disp(6'(r), 4'(r), 32'hdead, 32'(r * 3), 1'b1, 4'(r ^ 8), 1'b0, 4'd0);
            tick();
        end
        idle();
        check("full_set", bus.rs_full, 1);
        check("full_cnt", bus.rs_count, 8);
        set_disp(6'd9, 4'd9, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        idle();
        check("drop_cnt", bus.rs_count, 8);
        check("drop_full", bus.rs_full, 1);

        // Wake 8, 3, 1 while the slot is stalled; age order must be 1, 3, 8
        sb_q.push_back(pk(6'd1, 4'd1, 32'h101, 32'd3));
        sb_q.push_back(pk(6'd3, 4'd3, 32'h103, 32'd9));
        sb_q.push_back(pk(6'd8, 4'd8, 32'h108, 32'd24));
        set_cdb(0, 4'd0, 32'h108);
        tick();
        check("hold_rob_a", bus.iss_robid, 0);
        idle();
        set_cdb(0, 4'd11, 32'h103);
        tick();
        check("hold_rob_b", bus.iss_robid, 0);
        idle();
        set_cdb(0, 4'd9, 32'h101);
        tick();
        idle();
        check("hold_rob_c", bus.iss_robid, 0);
        check("hold_op", bus.iss_op, 6'h3f);
        check("hold_vld", bus.iss_valid, 1);
        bus.iss_ready = 1'b1;
        tick();
        check("full_clr", bus.rs_full, 0);
        check("cnt_7", bus.rs_count, 7);
        check("age_1", bus.iss_robid, 1);
        tick();
        check("age_3", bus.iss_robid, 3);
        tick();
        check("age_8", bus.iss_robid, 8);
        tick();
        check("drain_vld", bus.iss_valid, 0);
        check("drain_cnt", bus.rs_count, 5);

        // Flush with 5 resident entries and a stalled slot
        bus.iss_ready = 1'b0;
        set_cdb(0, 4'd10, 32'h102);
        tick();
        idle();
        tick();
        set_disp(6'd10, 4'd10, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        idle();
        check("pre_clr_cnt", bus.rs_count, 5);
        check("pre_clr_vld", bus.iss_valid, 1);
        rs_clear = 1'b1;
        tick();
        rs_clear = 1'b0;
        check("clr_cnt", bus.rs_count, 0);
        check("clr_vld", bus.iss_valid, 0);
        check("clr_full", bus.rs_full, 0);
        bus.iss_ready = 1'b1;
        for (int r = 4; r <= 7; r++) begin
            set_cdb(0, 4'(r ^ 8), 32'(r));
            tick();
            idle();
            tick();
            check("stale_vld", bus.iss_valid, 0);
        end

        repeat (3) tick();
        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
